// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with a 2-entry skid buffer,
// registered valid/ready handshake, synchronous flush and bubble value.
module pipe_skid_reg #(
    parameter int unsigned   DW      = 64,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          rdy_q, vld_q;
    logic          in_fire, out_fire;

    assign in_fire  = in_valid_i & rdy_q;
    assign out_fire = vld_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: main_d = in_data_i;
                        2'b10: begin
                            skid_d  = in_data_i;
                            state_d = FULL;
                        end
                        2'b01: begin
                            main_d  = RST_VAL;
                            state_d = EMPTY;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    // skid is always the younger entry, so it moves up
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = RST_VAL;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = RST_VAL;
                    skid_d  = RST_VAL;
                end
            endcase
        end
    end

    // Handshake outputs get their own flops so ready/valid leave the
    // stage straight from a register, with no decode behind them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != FULL);
            vld_q   <= (state_d != EMPTY);
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = vld_q;
    assign out_data_o  = main_q;
    assign count_o     = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random checks of pipe_skid_reg against
// a queue-based reference model and an output scoreboard.
module tb_pipe_skid_reg;

    localparam int unsigned   DW      = 16;
    localparam logic [DW-1:0] RST_VAL = 16'h0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [1:0]    count_o;

    pipe_skid_reg #(.DW(DW), .RST_VAL(RST_VAL)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] held[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    // Reference: the stage is a FIFO of depth two that refuses input when
    // full, drops everything on flush/reset and never takes the flush-cycle input.
    always @(posedge clk) begin : model
        int n;
        bit of, inf;
        n   = held.size();
        of  = (n > 0) && out_ready_i;
        inf = (n < 2) && in_valid_i;
        if (!rst || flush_i) begin
            held.delete();
            exp_q.delete();
        end else begin
            if (of) void'(held.pop_front());
            if (inf) begin
                held.push_back(in_data_i);
                exp_q.push_back(in_data_i);
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        if (mon_en) begin
            chk("count", 32'(count_o), 32'(held.size()));
            chk("in_ready", 32'(in_ready_o), 32'(held.size() < 2));
            chk("out_valid", 32'(out_valid_o), 32'(held.size() != 0));
            if (!out_valid_o)
                chk("bubble", 32'(out_data_o), 32'(RST_VAL));
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(out_data_o), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data_o), 32'(e));
                end
            end
        end
    end

    task automatic cyc(input logic rs, input logic v, input logic [DW-1:0] d,
                       input logic r, input logic f);
        rst         = rs;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_state(input string nm, input logic [1:0] c,
                             input logic v, input logic rd,
                             input logic [DW-1:0] d);
        chk({nm, ".count"}, 32'(count_o), 32'(c));
        chk({nm, ".valid"}, 32'(out_valid_o), 32'(v));
        chk({nm, ".ready"}, 32'(in_ready_o), 32'(rd));
        chk({nm, ".data"}, 32'(out_data_o), 32'(d));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(0, 1, 16'hDEAD, 0, 0);
        mon_en = 1'b1;
        cyc(0, 1, 16'hDEAD, 0, 0);
        chk_state("reset", 2'd0, 0, 1, RST_VAL);
        cyc(1, 1, 16'h0042, 0, 0);
        chk_state("rel", 2'd1, 1, 1, 16'h0042);
        cyc(1, 0, 16'h0000, 0, 1);
        chk_state("fl0", 2'd0, 0, 1, RST_VAL);

        cyc(1, 1, 16'h0001, 1, 0);
        chk_state("st1", 2'd1, 1, 1, 16'h0001);
        cyc(1, 1, 16'h0002, 1, 0);
        chk_state("st2", 2'd1, 1, 1, 16'h0002);
        cyc(1, 1, 16'h0003, 1, 0);
        chk_state("st3", 2'd1, 1, 1, 16'h0003);
        cyc(1, 0, 16'h0000, 1, 0);
        chk_state("st_end", 2'd0, 0, 1, RST_VAL);

        cyc(1, 1, 16'h000A, 0, 0);
        chk_state("fillA", 2'd1, 1, 1, 16'h000A);
        cyc(1, 1, 16'h000B, 0, 0);
        chk_state("fillB", 2'd2, 1, 0, 16'h000A);
        cyc(1, 1, 16'h000C, 0, 0);
        chk_state("fillC", 2'd2, 1, 0, 16'h000A);
        cyc(1, 1, 16'h000C, 1, 0);
        chk_state("drA", 2'd1, 1, 1, 16'h000B);
        cyc(1, 1, 16'h000C, 1, 0);
        chk_state("drB", 2'd1, 1, 1, 16'h000C);
        cyc(1, 0, 16'h0000, 1, 0);
        chk_state("drC", 2'd0, 0, 1, RST_VAL);

        cyc(1, 1, 16'h0005, 0, 0);
        cyc(1, 1, 16'h0006, 1, 0);
        chk_state("simul", 2'd1, 1, 1, 16'h0006);
        cyc(1, 0, 16'h0000, 1, 0);

        cyc(1, 1, 16'h0007, 0, 0);
        cyc(1, 1, 16'h0008, 0, 0);
        chk_state("pre_fl", 2'd2, 1, 0, 16'h0007);
        cyc(1, 1, 16'h0009, 0, 1);
        chk_state("flush", 2'd0, 0, 1, RST_VAL);
        cyc(1, 0, 16'h0000, 1, 0);
        chk_state("post_fl", 2'd0, 0, 1, RST_VAL);

        cyc(1, 1, 16'h0004, 0, 0);
        cyc(0, 1, 16'h0077, 1, 1);
        chk_state("rst_all", 2'd0, 0, 1, RST_VAL);

        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 499) != 0),
                ($urandom_range(0, 3) != 0),
                DW'($urandom),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 4; i++) cyc(1, 0, 16'h0000, 1, 0);
        chk("drained", 32'(exp_q.size()), 32'd0);
        chk_state("final", 2'd0, 0, 1, RST_VAL);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
